// File: rtl/tl_inflight_monitor.sv
// tl_inflight_monitor
//   Passive TileLink-UL protocol monitor. Snoops one A (request) and one D
//   (response) channel, tracks in-flight source IDs and multi-beat bursts,
//   and checks payload stability, opcode/size pairing and response latency.
//   Never drives the link; every output is registered.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   a_valid/a_ready       A handshake (fire = valid & ready)
//   a_opcode/a_param/a_size/a_source/a_address   A payload
//   d_valid/d_ready       D handshake
//   d_opcode/d_size/d_source/d_denied            D payload
//   err_valid             one-cycle pulse, one cycle after a detected error
//   err_code              lowest error bit raised in the flagged cycle
//   err_vec               sticky error bits, cleared only by reset
//   inflight_count        number of sources currently in flight
//
// Error bits
//   0 payload instability / burst field mismatch   1 illegal opcode or param
//   2 misaligned address    3 source reused while in flight
//   4 D on idle source      5 D opcode mismatch     6 D size mismatch
//   7 response watchdog timeout
module tl_inflight_monitor #(
    parameter int SOURCE_BITS = 4,
    parameter int ADDR_BITS   = 32,
    parameter int SIZE_BITS   = 3,
    parameter int BEAT_LOG2   = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_param,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic                   d_denied,
    output logic                   err_valid,
    output logic [2:0]             err_code,
    output logic [7:0]             err_vec,
    output logic [SOURCE_BITS:0]   inflight_count
);

    localparam int NSRC  = 1 << SOURCE_BITS;
    localparam int CNT_W = 1 << SIZE_BITS;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int A_PW  = 6 + SIZE_BITS + SOURCE_BITS + ADDR_BITS;
    localparam int D_PW  = 4 + SIZE_BITS + SOURCE_BITS;

    // Index of the last beat of a message (0 for single-beat messages).
    function automatic logic [CNT_W-1:0] last_beat(input logic multi,
                                                   input logic [SIZE_BITS-1:0] size);
        if (multi && (int'(size) > BEAT_LOG2))
            return (CNT_W'(1) << (int'(size) - BEAT_LOG2)) - CNT_W'(1);
        return '0;
    endfunction

    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    logic a_fire, d_fire;
    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    // Burst tracking: counters are control, captured burst context is data.
    logic [CNT_W-1:0]       a_cnt, d_cnt, a_last_q, d_last_q, a_last_idx, d_last_idx;
    logic [SIZE_BITS-1:0]   a_bsize_q, d_bsize_q;
    logic [SOURCE_BITS-1:0] a_bsrc_q, d_bsrc_q;
    logic                   a_first, d_first, a_last, d_last;
    logic                   a_first_fire, d_first_fire, d_last_fire;

    assign a_first      = (a_cnt == '0);
    assign d_first      = (d_cnt == '0);
    assign a_last_idx   = a_first ? last_beat((a_opcode == 3'd0) || (a_opcode == 3'd1), a_size)
                                  : a_last_q;
    assign d_last_idx   = d_first ? last_beat(d_opcode == 3'd1, d_size) : d_last_q;
    assign a_last       = (a_cnt == a_last_idx);
    assign d_last       = (d_cnt == d_last_idx);
    assign a_first_fire = a_fire & a_first;
    assign d_first_fire = d_fire & d_first;
    assign d_last_fire  = d_fire & d_last;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (a_fire) a_cnt <= a_last ? '0 : a_cnt + CNT_W'(1);
            if (d_fire) d_cnt <= d_last ? '0 : d_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (a_first_fire) begin
            a_last_q  <= a_last_idx;
            a_bsize_q <= a_size;
            a_bsrc_q  <= a_source;
        end
        if (d_first_fire) begin
            d_last_q  <= d_last_idx;
            d_bsize_q <= d_size;
            d_bsrc_q  <= d_source;
        end
    end

    // Stability: remember whether each channel was stalled last cycle and
    // what it was presenting; any change (or dropped valid) is a violation.
    logic            a_hold_q, d_hold_q;
    logic [A_PW-1:0] a_pay, a_snap_q;
    logic [D_PW-1:0] d_pay, d_snap_q;

    assign a_pay = {a_opcode, a_param, a_size, a_source, a_address};
    assign d_pay = {d_opcode, d_denied, d_size, d_source};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_hold_q <= 1'b0;
            d_hold_q <= 1'b0;
        end else begin
            a_hold_q <= a_valid & ~a_ready;
            d_hold_q <= d_valid & ~d_ready;
        end
    end

    always_ff @(posedge clock) begin
        a_snap_q <= a_pay;
        d_snap_q <= d_pay;
    end

    // Per-source table. Only the in-flight bits are control state; the
    // expected response fields are meaningful only while in flight.
    logic [NSRC-1:0]                 inflight_q, inflight_nxt, exp_op_q;
    logic [NSRC-1:0][SIZE_BITS-1:0]  exp_size_q;
    logic [SOURCE_BITS:0]            count_nxt;

    always_ff @(posedge clock) begin
        if (a_first_fire) begin
            exp_op_q[a_source]   <= (a_opcode == 3'd4);
            exp_size_q[a_source] <= a_size;
        end
    end

    // Set is applied after clear so a same-cycle retire/reissue stays in flight.
    always_comb begin
        inflight_nxt = inflight_q;
        if (d_last_fire)  inflight_nxt[d_source] = 1'b0;
        if (a_first_fire) inflight_nxt[a_source] = 1'b1;
        count_nxt = '0;
        for (int i = 0; i < NSRC; i++)
            count_nxt = count_nxt + (SOURCE_BITS + 1)'(inflight_nxt[i]);
    end

    // Watchdog: fires once when the stall reaches TIMEOUT, then saturates.
    logic wd_hit;
    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_W-1:0] wd;
            always_ff @(posedge clock) begin
                if (!reset_n)
                    wd <= '0;
                else if (d_fire || (inflight_count == '0))
                    wd <= '0;
                else if (wd != WD_W'(TIMEOUT))
                    wd <= wd + WD_W'(1);
            end
            assign wd_hit = !d_fire && (inflight_count != '0) && (wd == WD_W'(TIMEOUT - 1));
        end else begin : g_no_wd
            assign wd_hit = 1'b0;
        end
    endgenerate

    logic [7:0]           err_now;
    logic [ADDR_BITS-1:0] a_mask;
    assign a_mask = (ADDR_BITS'(1) << a_size) - ADDR_BITS'(1);

    always_comb begin
        err_now    = '0;
        err_now[0] = (a_hold_q && (!a_valid || (a_pay != a_snap_q)))
                   | (d_hold_q && (!d_valid || (d_pay != d_snap_q)))
                   | (a_fire && !a_first && ((a_size != a_bsize_q) || (a_source != a_bsrc_q)))
                   | (d_fire && !d_first && ((d_size != d_bsize_q) || (d_source != d_bsrc_q)));
        err_now[1] = a_fire && (!(a_opcode inside {3'd0, 3'd1, 3'd4}) || (a_param != 3'd0));
        err_now[2] = a_first_fire && ((a_address & a_mask) != '0);
        err_now[3] = a_first_fire && inflight_q[a_source]
                   && !(d_last_fire && (d_source == a_source));
        err_now[4] = d_fire && !inflight_q[d_source];
        err_now[5] = d_first_fire && inflight_q[d_source]
                   && (d_opcode != {2'b00, exp_op_q[d_source]});
        err_now[6] = d_first_fire && inflight_q[d_source]
                   && (d_size != exp_size_q[d_source]);
        err_now[7] = wd_hit;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inflight_q     <= '0;
            inflight_count <= '0;
            err_valid      <= 1'b0;
            err_code       <= 3'd0;
            err_vec        <= 8'd0;
        end else begin
            inflight_q     <= inflight_nxt;
            inflight_count <= count_nxt;
            err_valid      <= |err_now;
            err_code       <= lowest_bit(err_now);
            err_vec        <= err_vec | err_now;
        end
    end

endmodule
